// File: rtl/traffic_pkg.sv
// Shared definitions for the two-direction traffic-light sequencer.
//  - state_t  : FSM state encoding (four normal phases plus NIGHT)
//  - lamp_t   : one direction's {red, yellow, green} lamp set
//  - LAMP_*   : lamp-vector constants used by the output decode
//  - next_state / is_green_state : sequencing helpers for the normal cycle
package traffic_pkg;

  typedef enum logic [2:0] {
    S_G1R2  = 3'd0,
    S_Y1R2  = 3'd1,
    S_R1G2  = 3'd2,
    S_R1Y2  = 3'd3,
    S_NIGHT = 3'd4
  } state_t;

  typedef struct packed {
    logic r;
    logic y;
    logic g;
  } lamp_t;

  localparam lamp_t LAMP_R   = 3'b100;
  localparam lamp_t LAMP_Y   = 3'b010;
  localparam lamp_t LAMP_G   = 3'b001;
  localparam lamp_t LAMP_OFF = 3'b000;

  // Successor in the normal cycle; anything outside it restarts at G1R2.
  function automatic state_t next_state(input state_t s);
    case (s)
      S_G1R2:  return S_Y1R2;
      S_Y1R2:  return S_R1G2;
      S_R1G2:  return S_R1Y2;
      S_R1Y2:  return S_G1R2;
      default: return S_G1R2;
    endcase
  endfunction

  // Green phases use the long duration, yellow phases the short one.
  function automatic logic is_green_state(input state_t s);
    return (s == S_G1R2) || (s == S_R1G2);
  endfunction

endpackage

// File: rtl/traffic_control.sv
// Two-direction intersection traffic-light sequencer (Moore FSM).
// Ports:
//  CLK      in   system clock, rising edge
//  RST      in   synchronous, active-high reset
//  EN_in    in   [0] one-cycle time tick, [1] hold/freeze
//  SW1      in   1 = normal sequencing, 0 = night (flashing yellow)
//  Red1/Yellow1/Green1  out  direction-1 lamps
//  Red2/Yellow2/Green2  out  direction-2 lamps
// Each normal phase lasts exactly its duration in ticks: the countdown is
// loaded with duration-1 and the phase advances on the tick that finds 0.
module traffic_control
  import traffic_pkg::*;
#(
  parameter int GREEN_TIME  = 25,
  parameter int YELLOW_TIME = 5,
  parameter int CNT_W       = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] EN_in,
  input  logic       SW1,
  output logic       Red1,
  output logic       Yellow1,
  output logic       Green1,
  output logic       Red2,
  output logic       Yellow2,
  output logic       Green2
);

  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TIME - 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             flash;
  logic             tick;
  lamp_t            lamp1;
  lamp_t            lamp2;

  // Hold masks the tick, so a tick arriving during a freeze is dropped.
  assign tick = EN_in[0] && !EN_in[1];
  assign nxt  = next_state(state);

  // NOTE: reset is synchronous here, so it lives inside the clocked branch
  // rather than in the sensitivity list; state uses <= so every register
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_G1R2;
      cnt   <= GREEN_LOAD;
      flash <= 1'b0;
    end else if (!SW1) begin
      if (state != S_NIGHT) begin
        // Entering night: count is left as-is, flashing starts dark.
        state <= S_NIGHT;
        flash <= 1'b0;
      end else if (tick) begin
        flash <= ~flash;
      end
    end else begin
      case (state)
        S_G1R2, S_Y1R2, S_R1G2, S_R1Y2: begin
          if (tick) begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              state <= nxt;
              cnt   <= is_green_state(nxt) ? GREEN_LOAD : YELLOW_LOAD;
            end
          end
        end
        // Leaving NIGHT and recovering from an illegal encoding both
        // restart the cycle with a full green, regardless of hold.
        default: begin
          state <= S_G1R2;
          cnt   <= GREEN_LOAD;
          flash <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: both lamp sets get a default before the case so no path leaves
  // them unassigned, which would otherwise infer latches.
  always_comb begin
    lamp1 = LAMP_R;
    lamp2 = LAMP_R;
    case (state)
      S_G1R2:  lamp1 = LAMP_G;
      S_Y1R2:  lamp1 = LAMP_Y;
      S_R1G2:  lamp2 = LAMP_G;
      S_R1Y2:  lamp2 = LAMP_Y;
      S_NIGHT: begin
        lamp1 = flash ? LAMP_Y : LAMP_OFF;
        lamp2 = flash ? LAMP_Y : LAMP_OFF;
      end
      default: ;  // illegal encoding shows all-red until recovery
    endcase
  end

  assign Red1    = lamp1.r;
  assign Yellow1 = lamp1.y;
  assign Green1  = lamp1.g;
  assign Red2    = lamp2.r;
  assign Yellow2 = lamp2.y;
  assign Green2  = lamp2.g;

endmodule

// File: tb/tb_traffic_control.sv
// Directed self-checking bench for traffic_control with GREEN_TIME=3,
// YELLOW_TIME=2. Lamp vectors are {Red1,Yellow1,Green1,Red2,Yellow2,Green2}.
module tb_traffic_control;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] EN_in;
  logic       SW1;
  logic       Red1, Yellow1, Green1, Red2, Yellow2, Green2;
  logic [5:0] lamps;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] L_G1R2  = 6'b001_100;
  localparam logic [5:0] L_Y1R2  = 6'b010_100;
  localparam logic [5:0] L_R1G2  = 6'b100_001;
  localparam logic [5:0] L_R1Y2  = 6'b100_010;
  localparam logic [5:0] L_DARK  = 6'b000_000;
  localparam logic [5:0] L_FLASH = 6'b010_010;

  traffic_control #(
    .GREEN_TIME (3),
    .YELLOW_TIME(2),
    .CNT_W      (5)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .EN_in  (EN_in),
    .SW1    (SW1),
    .Red1   (Red1),
    .Yellow1(Yellow1),
    .Green1 (Green1),
    .Red2   (Red2),
    .Yellow2(Yellow2),
    .Green2 (Green2)
  );

  always #5 CLK = ~CLK;

  assign lamps = {Red1, Yellow1, Green1, Red2, Yellow2, Green2};

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = lamps;
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: lamps observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Safety invariant on every cycle: whenever a red or green is lit we are
  // in a normal phase, so each direction shows exactly one lamp and at
  // least one direction is red; otherwise (night) both yellows match.
  task automatic inv_check();
    logic ok;
    logic any_rg;
    any_rg = Red1 | Green1 | Red2 | Green2;
    if (any_rg)
      ok = ((32'(Red1) + 32'(Yellow1) + 32'(Green1)) == 1) &&
           ((32'(Red2) + 32'(Yellow2) + 32'(Green2)) == 1) &&
           (Red1 || Red2);
    else
      ok = (Yellow1 === Yellow2);
    checks++;
    assert (ok === 1'b1)
    else begin
      errors++;
      $error("FAIL invariant: lamps observed=%b expected=one-per-dir/one-red or matching yellows", lamps);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      inv_check();
    end
  endtask

  // One tick pulse, check the lamps right after the sampling edge, then
  // three idle clocks so ticks arrive every four clocks.
  task automatic tick_check(input string tag, input logic [5:0] exp);
    EN_in[0] = 1'b1;
    cycle(1);
    EN_in[0] = 1'b0;
    check(tag, exp);
    cycle(3);
  endtask

  initial begin
    RST   = 1'b1;
    EN_in = 2'b00;
    SW1   = 1'b1;

    // 1. Reset and idle hold
    cycle(2);
    RST = 1'b0;
    check("reset_g1r2", L_G1R2);
    cycle(6);
    check("idle_no_tick", L_G1R2);

    // 2. Full cycle: G1R2 x3, Y1R2 x2, R1G2 x3, R1Y2 x2
    tick_check("g1r2_t1", L_G1R2);
    tick_check("g1r2_t2", L_G1R2);
    tick_check("g1r2_t3_to_y1r2", L_Y1R2);
    tick_check("y1r2_t1", L_Y1R2);
    tick_check("y1r2_t2_to_r1g2", L_R1G2);
    tick_check("r1g2_t1", L_R1G2);
    tick_check("r1g2_t2", L_R1G2);
    tick_check("r1g2_t3_to_r1y2", L_R1Y2);
    tick_check("r1y2_t1", L_R1Y2);
    tick_check("r1y2_t2_to_g1r2", L_G1R2);

    // 3. Hold with tick held high for 5 clocks mid-G1R2
    tick_check("pre_hold_t1", L_G1R2);
    EN_in = 2'b11;
    for (int i = 0; i < 5; i++) begin
      cycle(1);
      check($sformatf("hold_%0d", i), L_G1R2);
    end
    EN_in = 2'b00;
    cycle(2);
    tick_check("post_hold_t2", L_G1R2);
    tick_check("post_hold_t3_to_y1r2", L_Y1R2);

    // 4. Night mode entered from R1G2
    tick_check("y1r2_t1_b", L_Y1R2);
    tick_check("y1r2_t2_to_r1g2_b", L_R1G2);
    tick_check("r1g2_t1_b", L_R1G2);
    SW1 = 1'b0;
    cycle(1);
    check("night_enter_dark", L_DARK);
    tick_check("night_flash_on", L_FLASH);
    EN_in = 2'b11;
    cycle(2);
    EN_in = 2'b00;
    check("night_hold_frozen", L_FLASH);
    tick_check("night_flash_off", L_DARK);
    SW1 = 1'b1;
    cycle(1);
    check("night_exit_g1r2", L_G1R2);
    tick_check("exit_t1", L_G1R2);
    tick_check("exit_t2", L_G1R2);
    tick_check("exit_t3_to_y1r2", L_Y1R2);

    // 5. Reset beats a concurrent tick mid-Y1R2, reloading a full green
    RST   = 1'b1;
    EN_in = 2'b01;
    cycle(1);
    RST   = 1'b0;
    EN_in = 2'b00;
    check("reset_over_tick", L_G1R2);
    cycle(2);
    tick_check("after_rst_t1", L_G1R2);
    tick_check("after_rst_t2", L_G1R2);
    tick_check("after_rst_t3_to_y1r2", L_Y1R2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
